// File: rtl/axi_shell_mem_responder.sv
// -----------------------------------------------------------------------------
// axi_shell_mem_responder
//   Terminating AXI4 slave for a shell data FIFO master. Writes land in an
//   internal MEM_DEPTH x AXI_DATA_BITS array and reads are served from it.
//   The word index is addr[log2(bytes/beat) +: log2(MEM_DEPTH)]. Higher
//   address bits alias, so there is never a DECERR.
//
// Ports
//   aclk, aresetn      : single clock (rising edge); async assert, active-low reset
//   s_axi_aw*          : write address channel (awready high only in W_IDLE)
//   s_axi_w*           : write data channel    (wready high only in W_DATA)
//   s_axi_b*           : write response        (bvalid high only in W_RESP)
//   s_axi_ar*          : read address channel  (arready high only in R_IDLE)
//   s_axi_r*           : read data channel     (rvalid high only in R_DATA)
//   o_dbg_wstate       : current write FSM state
//   o_dbg_rstate       : current read FSM state
//
// Handshake rule, all channels: a transfer happens on the rising edge where
// valid and ready are both high. A source holds its payload stable while it
// holds valid without ready. Ready never depends combinationally on valid.
// -----------------------------------------------------------------------------
module axi_shell_mem_responder #(
  parameter int AXI_DATA_BITS = 512,
  parameter int AXI_ADDR_BITS = 64,
  parameter int AXI_ID_BITS   = 6,
  parameter int MEM_DEPTH     = 64
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  // write address
  input  logic [AXI_ID_BITS-1:0]     s_axi_awid,
  input  logic [AXI_ADDR_BITS-1:0]   s_axi_awaddr,
  input  logic [7:0]                 s_axi_awlen,
  input  logic [2:0]                 s_axi_awsize,
  input  logic [1:0]                 s_axi_awburst,
  input  logic                       s_axi_awlock,
  input  logic [3:0]                 s_axi_awcache,
  input  logic [2:0]                 s_axi_awprot,
  input  logic [3:0]                 s_axi_awqos,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  // write data
  input  logic [AXI_DATA_BITS-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_BITS/8-1:0] s_axi_wstrb,
  input  logic                       s_axi_wlast,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  // write response
  output logic [AXI_ID_BITS-1:0]     s_axi_bid,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  // read address
  input  logic [AXI_ID_BITS-1:0]     s_axi_arid,
  input  logic [AXI_ADDR_BITS-1:0]   s_axi_araddr,
  input  logic [7:0]                 s_axi_arlen,
  input  logic [2:0]                 s_axi_arsize,
  input  logic [1:0]                 s_axi_arburst,
  input  logic                       s_axi_arlock,
  input  logic [3:0]                 s_axi_arcache,
  input  logic [2:0]                 s_axi_arprot,
  input  logic [3:0]                 s_axi_arqos,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  // read data
  output logic [AXI_ID_BITS-1:0]     s_axi_rid,
  output logic [AXI_DATA_BITS-1:0]   s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rlast,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  // debug
  output logic [1:0]                 o_dbg_wstate,
  output logic                       o_dbg_rstate
);

  localparam int BYTES = AXI_DATA_BITS / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int IDXW  = $clog2(MEM_DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(OFFS);

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  // Sizes wider than the bus behave as full-width beats.
  function automatic logic [2:0] f_clamp(input logic [2:0] size);
    return (size > MAX_SIZE) ? MAX_SIZE : size;
  endfunction

  // INCR steps by 2^size bytes. FIXED (and the erroring WRAP/reserved) hold.
  function automatic logic [AXI_ADDR_BITS-1:0] f_next(input logic [AXI_ADDR_BITS-1:0] addr,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    if (burst == BURST_INCR) return addr + (AXI_ADDR_BITS'(1) << size);
    return addr;
  endfunction

  function automatic logic [IDXW-1:0] f_idx(input logic [AXI_ADDR_BITS-1:0] addr);
    return addr[OFFS +: IDXW];
  endfunction

  logic [AXI_DATA_BITS-1:0] r_mem [MEM_DEPTH];

  // ---------------------------------------------------------------- write side
  wstate_t                  r_wstate;
  logic                     r_awready;
  logic                     r_wready;
  logic                     r_bvalid;
  logic [1:0]               r_bresp;
  logic [AXI_ID_BITS-1:0]   r_awid;
  logic [AXI_ADDR_BITS-1:0] r_waddr;
  logic [7:0]               r_awlen;
  logic [2:0]               r_awsize;
  logic [1:0]               r_awburst;
  logic [7:0]               r_wcnt;
  logic                     r_werr;

  logic w_wbeat;
  logic w_wlast_exp;
  logic w_wlast_bad;
  logic w_wburst_bad;

  assign w_wbeat      = s_axi_wvalid && r_wready;
  assign w_wlast_exp  = (r_wcnt == r_awlen);
  assign w_wlast_bad  = (s_axi_wlast != w_wlast_exp);
  assign w_wburst_bad = r_awburst[1];  // WRAP (10) or reserved (11)

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_awid    <= '0;
      r_waddr   <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= '0;
      r_wcnt    <= '0;
      r_werr    <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          // Covers the first cycle out of reset as well as returns from W_RESP.
          r_awready <= 1'b1;
          if (s_axi_awvalid && r_awready) begin
            r_awid    <= s_axi_awid;
            r_waddr   <= s_axi_awaddr;
            r_awlen   <= s_axi_awlen;
            r_awsize  <= f_clamp(s_axi_awsize);
            r_awburst <= s_axi_awburst;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_wbeat) begin
            r_waddr <= f_next(r_waddr, r_awsize, r_awburst);
            if (w_wlast_exp) begin
              // The counter ends the burst, not wlast; a missing or early
              // wlast is only reported through bresp.
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (w_wburst_bad || r_werr || w_wlast_bad) ? RESP_SLVERR : RESP_OKAY;
              r_wstate <= W_RESP;
            end else begin
              r_wcnt <= r_wcnt + 8'd1;
              if (w_wlast_bad) r_werr <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (r_bvalid && s_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset. Bad bursts consume beats without writing.
  always_ff @(posedge aclk) begin
    if (w_wbeat && !w_wburst_bad) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s_axi_wstrb[b]) r_mem[f_idx(r_waddr)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read side
  rstate_t                  r_rstate;
  logic                     r_arready;
  logic                     r_rvalid;
  logic                     r_rlast;
  logic [1:0]               r_rresp;
  logic [AXI_DATA_BITS-1:0] r_rdata;
  logic [AXI_ID_BITS-1:0]   r_arid;
  logic [AXI_ADDR_BITS-1:0] r_raddr;
  logic [7:0]               r_arlen;
  logic [2:0]               r_arsize;
  logic [1:0]               r_arburst;
  logic [7:0]               r_rcnt;

  logic [7:0] w_rcnt_nxt;
  logic       w_arburst_bad;

  assign w_rcnt_nxt    = r_rcnt + 8'd1;
  assign w_arburst_bad = s_axi_arburst[1];

  // r_raddr always points at the beat after the one held in r_rdata. Memory
  // reads use the pre-edge array contents, so a same-edge write to that index
  // is not seen (read-first).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
      r_arid    <= '0;
      r_raddr   <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_rcnt    <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (s_axi_arvalid && r_arready) begin
            r_arid    <= s_axi_arid;
            r_arlen   <= s_axi_arlen;
            r_arsize  <= f_clamp(s_axi_arsize);
            r_arburst <= s_axi_arburst;
            r_rcnt    <= '0;
            r_rlast   <= (s_axi_arlen == 8'd0);
            r_rresp   <= w_arburst_bad ? RESP_SLVERR : RESP_OKAY;
            r_rdata   <= w_arburst_bad ? '0 : r_mem[f_idx(s_axi_araddr)];
            r_raddr   <= f_next(s_axi_araddr, f_clamp(s_axi_arsize), s_axi_arburst);
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_rvalid && s_axi_rready) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_rcnt  <= w_rcnt_nxt;
              r_rlast <= (w_rcnt_nxt == r_arlen);
              r_rdata <= r_arburst[1] ? '0 : r_mem[f_idx(r_raddr)];
              r_raddr <= f_next(r_raddr, r_arsize, r_arburst);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------ outputs
  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_bid     = r_awid;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rid     = r_arid;
  assign o_dbg_wstate  = r_wstate;
  assign o_dbg_rstate  = r_rstate;

  // Attribute signals carried by AXI4 that a plain memory has no use for.
  logic w_unused_attrs;
  assign w_unused_attrs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                            s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

endmodule

// File: tb/tb_axi_shell_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_axi_shell_mem_responder
//   Directed, self-checking bench for axi_shell_mem_responder. It uses a
//   64-bit bus, 16-word memory and 32-bit addresses. A bench-side memory model
//   supplies the expected read data. The B and R scoreboards push
//   expectations when stimulus is driven and pop them when beats handshake.
// -----------------------------------------------------------------------------
module tb_axi_shell_mem_responder;

  localparam int DW    = 64;
  localparam int AW    = 32;
  localparam int IW    = 4;
  localparam int DEPTH = 16;
  localparam int RW    = IW + 2 + 1 + DW;  // {rid, rresp, rlast, rdata}
  localparam int BW    = IW + 2;           // {bid, bresp}

  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
  localparam logic [1:0] OKAY  = 2'b00, SLVERR = 2'b10;

  // ------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT I/O
  logic [IW-1:0]   awid = '0, arid = '0, bid, rid;
  logic [AW-1:0]   awaddr = '0, araddr = '0;
  logic [7:0]      awlen = '0, arlen = '0;
  logic [2:0]      awsize = '0, arsize = '0;
  logic [1:0]      awburst = '0, arburst = '0, bresp, rresp;
  logic            awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic            bready = 1'b0, rready = 1'b0;
  logic            awready, arready, wready, bvalid, rvalid, rlast;
  logic [DW-1:0]   wdata = '0, rdata;
  logic [DW/8-1:0] wstrb = '0;
  logic [1:0]      dbg_wstate;
  logic            dbg_rstate;

  axi_shell_mem_responder #(
    .AXI_DATA_BITS(DW), .AXI_ADDR_BITS(AW), .AXI_ID_BITS(IW), .MEM_DEPTH(DEPTH)
  ) dut (
    .aclk(clk), .aresetn(aresetn),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'h0), .s_axi_awprot(3'h0),
    .s_axi_awqos(4'h0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'h0), .s_axi_arprot(3'h0),
    .s_axi_arqos(4'h0), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .o_dbg_wstate(dbg_wstate), .o_dbg_rstate(dbg_rstate)
  );

  // ------------------------------------------------------------ scoreboard
  logic [RW-1:0] exp_r_q[$];
  logic [BW-1:0] exp_b_q[$];
  logic [DW-1:0] mem_model [DEPTH];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: compares on handshakes and checks that payloads hold while stalled.
  logic          r_stall = 1'b0, b_stall = 1'b0;
  logic [RW-1:0] r_hold = '0;
  logic [BW-1:0] b_hold = '0;
  always @(negedge clk) begin
    if (!aresetn) begin
      r_stall = 1'b0;
      b_stall = 1'b0;
    end else begin
      if (r_stall) chk("r_stable", {rid, rresp, rlast, rdata}, r_hold);
      if (rvalid && rready) begin
        chk("r_beat_expected", exp_r_q.size() > 0, 1);
        if (exp_r_q.size() > 0) chk("r_beat", {rid, rresp, rlast, rdata}, exp_r_q.pop_front());
      end
      r_stall = rvalid && !rready;
      r_hold  = {rid, rresp, rlast, rdata};

      if (b_stall) chk("b_stable", {bid, bresp}, b_hold);
      if (bvalid && bready) begin
        chk("b_beat_expected", exp_b_q.size() > 0, 1);
        if (exp_b_q.size() > 0) chk("b_beat", {bid, bresp}, exp_b_q.pop_front());
      end
      b_stall = bvalid && !bready;
      b_hold  = {bid, bresp};
    end
  end

  // ---------------------------------------------------------------- drivers
  // Every driver task starts 1 time unit after a rising edge and returns there.
  task automatic wr_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [DW-1:0] base,
                          input logic [DW/8-1:0] strb, input int last_at, input bit rand_b);
    logic          hs;
    int            n;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 100) begin
      @(negedge clk); hs = awready;
      @(posedge clk); n++;
    end
    #1 awvalid = 1'b0;
    chk("aw_handshake", hs, 1);
    exp_b_q.push_back({id, (burst[1] || last_at != int'(len)) ? SLVERR : OKAY});
    for (int i = 0; i <= int'(len); i++) begin
      wdata = base + DW'(i); wstrb = strb; wlast = (i == last_at); wvalid = 1'b1;
      hs = 1'b0; n = 0;
      while (!hs && n < 100) begin
        @(negedge clk); hs = wready;
        @(posedge clk); n++;
      end
      #1;
      chk("w_handshake", hs, 1);
    end
    wvalid = 1'b0; wlast = 1'b0;
    hs = 1'b0; n = 0;
    while (!hs && n < 200) begin
      bready = rand_b ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk); hs = bvalid && bready;
      @(posedge clk); #1; n++;
    end
    bready = 1'b0;
    chk("b_handshake", hs, 1);
    if (!burst[1]) begin
      a = addr;
      for (int i = 0; i <= int'(len); i++) begin
        d = base + DW'(i);
        for (int b = 0; b < DW/8; b++)
          if (strb[b]) mem_model[a[6:3]][8*b +: 8] = d[8*b +: 8];
        if (burst == INCR) a = a + 32'd8;
      end
    end
  endtask

  task automatic rd_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input bit rand_r);
    logic          hs;
    int            n, beats;
    logic [AW-1:0] a;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      exp_r_q.push_back({id, burst[1] ? SLVERR : OKAY, 1'(i == int'(len)),
                         burst[1] ? 64'd0 : mem_model[a[6:3]]});
      if (burst == INCR) a = a + 32'd8;
    end
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 100) begin
      @(negedge clk); hs = arready;
      @(posedge clk); n++;
    end
    #1 arvalid = 1'b0;
    chk("ar_handshake", hs, 1);
    chk("r_first_latency", rvalid, 1);
    beats = 0; n = 0;
    while (beats <= int'(len) && n < 1000) begin
      rready = rand_r ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk); if (rvalid && rready) beats++;
      @(posedge clk); #1; n++;
    end
    rready = 1'b0;
    chk("r_beat_count", beats, int'(len) + 1);
  endtask

  // Bound on the whole run; any hang ends here.
  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  // --------------------------------------------------------------- sequence
  initial begin
    // Reset state
    #12;
    chk("rst_ctrl", {awready, wready, arready, bvalid, rvalid, rlast}, 0);
    chk("rst_payload", {bresp, rresp, bid, rid}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_states", {dbg_wstate, dbg_rstate}, 0);
    @(negedge clk) aresetn = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {awready, arready}, 2'b11);

    // Basic 4-beat INCR write then readback
    wr_burst(4'h3, 32'h0, 8'd3, 3'd3, INCR, 64'hA0, 8'hFF, 3, 1'b0);
    rd_burst(4'h5, 32'h0, 8'd3, 3'd3, INCR, 1'b0);

    // 16-beat bursts under random backpressure (fill the whole array)
    wr_burst(4'h7, 32'h0, 8'd15, 3'd3, INCR, 64'h1000, 8'hFF, 15, 1'b1);
    rd_burst(4'h9, 32'h0, 8'd15, 3'd3, INCR, 1'b1);
    rd_burst(4'hA, 32'h40, 8'd15, 3'd3, INCR, 1'b1);

    // Early wlast, missing wlast, WRAP write (memory untouched), WRAP read
    wr_burst(4'h1, 32'h0, 8'd3, 3'd3, INCR, 64'hB0, 8'hFF, 1, 1'b0);
    wr_burst(4'h2, 32'h10, 8'd1, 3'd3, INCR, 64'hC0, 8'hFF, 99, 1'b0);
    wr_burst(4'h4, 32'h40, 8'd3, 3'd3, WRAP, 64'hDEAD, 8'hFF, 3, 1'b0);
    rd_burst(4'h6, 32'h40, 8'd3, 3'd3, INCR, 1'b0);
    rd_burst(4'h8, 32'h40, 8'd1, 3'd3, WRAP, 1'b0);

    // Partial strobes, FIXED burst, oversize awsize/arsize, single beats, aliasing
    wr_burst(4'hB, 32'h60, 8'd0, 3'd3, INCR, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 1'b0);
    wr_burst(4'hC, 32'h60, 8'd0, 3'd3, INCR, 64'h1122_3344_5566_7788, 8'h0F, 0, 1'b0);
    rd_burst(4'hD, 32'h60, 8'd0, 3'd3, INCR, 1'b0);
    wr_burst(4'hE, 32'h38, 8'd3, 3'd3, FIXED, 64'h5500, 8'hFF, 3, 1'b0);
    rd_burst(4'hF, 32'h38, 8'd1, 3'd3, INCR, 1'b0);
    wr_burst(4'h1, 32'h50, 8'd1, 3'd7, INCR, 64'h7700, 8'hFF, 1, 1'b0);
    rd_burst(4'h2, 32'h50, 8'd1, 3'd7, INCR, 1'b0);
    rd_burst(4'h3, 32'h400, 8'd0, 3'd3, INCR, 1'b0);

    // Concurrent write and read starting at index 5; AR trails AW by one edge,
    // so every read load coincides with the write of that same index and
    // must return the old contents.
    fork
      wr_burst(4'h5, 32'h28, 8'd7, 3'd3, INCR, 64'h3000, 8'hFF, 7, 1'b0);
      begin
        @(posedge clk); #1;
        rd_burst(4'h6, 32'h28, 8'd7, 3'd3, INCR, 1'b0);
      end
    join
    rd_burst(4'h7, 32'h28, 8'd7, 3'd3, INCR, 1'b0);

    // Reset pulsed during beat 2 of an 8-beat read
    exp_r_q.push_back({4'h9, OKAY, 1'b0, mem_model[0]});
    exp_r_q.push_back({4'h9, OKAY, 1'b0, mem_model[1]});
    arid = 4'h9; araddr = 32'h0; arlen = 8'd7; arsize = 3'd3; arburst = INCR; arvalid = 1'b1;
    @(negedge clk); chk("abort_ar_ready", arready, 1);
    @(posedge clk); #1 arvalid = 1'b0; rready = 1'b1;
    @(posedge clk);
    @(posedge clk); #2 aresetn = 1'b0;
    #1;
    chk("abort_rvalid", rvalid, 0);
    chk("abort_ctrl", {arready, awready, rlast, bvalid}, 0);
    chk("abort_beats", exp_r_q.size(), 0);
    rready = 1'b0;
    @(posedge clk); #2 aresetn = 1'b1;
    @(posedge clk); #1;
    chk("abort_arready_after", arready, 1);
    chk("abort_awready_after", awready, 1);
    rd_burst(4'hA, 32'h0, 8'd3, 3'd3, INCR, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("r_queue_empty", exp_r_q.size(), 0);
    chk("b_queue_empty", exp_b_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
